// File: rtl/xgmii_ipg_tx_sched.sv
// xgmii_ipg_tx_sched: shares the 64-bit XGMII TX path between MAC frames and side words sent in the inter-packet gap.
// Optional macro SCHED_STATS_EN adds side-word and hold-cycle counters.
module xgmii_ipg_tx_sched #(
  parameter logic [7:0] SIDE_CHAR = 8'h5c,
  parameter int MAX_WAIT = 64,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] mac_txd,
  input  logic [7:0]  mac_txc,
  output logic        mac_tx_ready,
  input  logic [55:0] side_tdata,
  input  logic        side_tvalid,
  output logic        side_tready,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic [1:0]  sched_state
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0] stat_side_words,
  output logic [31:0] stat_hold_cycles
`endif
);
  localparam logic [63:0] IDLE_D = 64'h0707070707070707;
  typedef enum logic [1:0] {GAP = 2'd0, FRAME = 2'd1, HOLD = 2'd2} state_t;
  state_t state, nxt;
  logic [15:0] wait_cnt;
  logic [7:0] burst_cnt;
  logic is_idle, is_start, is_term, starve, hold_exit;
  logic [63:0] out_d;
  logic [7:0] out_c;
  assign is_idle = mac_txc == 8'hff && mac_txd == IDLE_D;
  assign is_start = (mac_txc[0] && mac_txd[7:0] == 8'hfb) || (mac_txc == 8'h1f && mac_txd[39:32] == 8'hfb);
  assign starve = wait_cnt >= 16'(MAX_WAIT);
  assign hold_exit = !side_tvalid || burst_cnt == 8'(MAX_BURST - 1);
  assign sched_state = state;
  always_comb begin
    is_term = 1'b0;
    for (int i = 0; i < 8; i++) is_term = is_term | (mac_txc[i] && mac_txd[8*i +: 8] == 8'hfd);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= GAP;
      wait_cnt <= '0;
      burst_cnt <= '0;
    end else begin
      state <= nxt;
      wait_cnt <= (!side_tvalid || side_tready) ? '0 : wait_cnt + {15'd0, wait_cnt != 16'hffff};
      burst_cnt <= (state != HOLD) ? '0 : burst_cnt + {7'd0, side_tready};
    end
  end
  // a lane-4 START also carrying a TERM is treated as START only, so START wins in GAP
  always_comb begin
    nxt = GAP;
    if (state == GAP) nxt = is_start ? FRAME : GAP;
    if (state == FRAME) nxt = is_term ? (starve ? HOLD : GAP) : FRAME;
    if (state == HOLD) nxt = hold_exit ? GAP : HOLD;
  end
  always_comb begin
    mac_tx_ready = !rst && state != HOLD;
    side_tready = !rst && side_tvalid && ((state == GAP && is_idle) || state == HOLD);
    out_d = rst ? IDLE_D : side_tready ? {side_tdata, SIDE_CHAR} : state == HOLD ? IDLE_D : mac_txd;
    out_c = (rst || side_tready || state == HOLD) ? 8'hff : mac_txc;
  end
  always_ff @(posedge clk) begin
    xgmii_txd <= out_d;
    xgmii_txc <= out_c;
  end
`ifdef SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_side_words <= '0;
      stat_hold_cycles <= '0;
    end else begin
      stat_side_words <= stat_side_words + {31'd0, side_tready};
      stat_hold_cycles <= stat_hold_cycles + {31'd0, state == HOLD};
    end
  end
`endif
endmodule

// File: tb/tb_xgmii_ipg_tx_sched.sv
// tb_xgmii_ipg_tx_sched: directed plus randomized checks of xgmii_ipg_tx_sched against a rule-level reference model.
module tb_xgmii_ipg_tx_sched;
  localparam int MW = 8;
  localparam int MB = 4;
  localparam logic [63:0] IDLE = 64'h0707070707070707;
  localparam logic [63:0] OS_D = 64'h070707070000009c;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] mac_txd = IDLE;
  logic [7:0] mac_txc = 8'hff;
  logic mac_tx_ready, side_tvalid = 1'b0, side_tready;
  logic [55:0] side_tdata = '0;
  logic [63:0] xgmii_txd;
  logic [7:0] xgmii_txc;
  logic [1:0] sched_state;
`ifdef SCHED_STATS_EN
  logic [31:0] stat_side_words, stat_hold_cycles;
`endif
  int checks = 0, errors = 0;
  int m_st = 0, m_wait = 0, m_burst = 0;
  logic [31:0] n_side = '0, n_hold = '0;
  logic [71:0] mq[$];
  xgmii_ipg_tx_sched #(.SIDE_CHAR(8'h5c), .MAX_WAIT(MW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .mac_txd(mac_txd), .mac_txc(mac_txc), .mac_tx_ready(mac_tx_ready),
    .side_tdata(side_tdata), .side_tvalid(side_tvalid), .side_tready(side_tready),
    .xgmii_txd(xgmii_txd), .xgmii_txc(xgmii_txc), .sched_state(sched_state)
`ifdef SCHED_STATS_EN
    , .stat_side_words(stat_side_words), .stat_hold_cycles(stat_hold_cycles)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  // one clock: drive inputs, check handshakes mid-cycle, advance the model, check the registered word
  task automatic step(input logic [63:0] d, input logic [7:0] c, input logic sv, input logic [55:0] sd, input logic r);
    logic idle, start, term, e_mr, e_sr, starve;
    logic [63:0] e_d;
    logic [7:0] e_c;
    mac_txd = d; mac_txc = c; side_tvalid = sv; side_tdata = sd; rst = r;
    idle = c == 8'hff && d == IDLE;
    start = (c[0] && d[7:0] == 8'hfb) || (c == 8'h1f && d[39:32] == 8'hfb);
    term = 1'b0;
    for (int i = 0; i < 8; i++) if (c[i] && d[8*i +: 8] == 8'hfd) term = 1'b1;
    e_mr = !r && m_st != 2;
    e_sr = !r && sv && (m_st == 2 || (m_st == 0 && idle));
    e_d = d; e_c = c;
    if (r || (m_st == 2 && !e_sr)) begin e_d = IDLE; e_c = 8'hff; end
    else if (e_sr) begin e_d = {sd, 8'h5c}; e_c = 8'hff; end
    @(negedge clk);
    chk("mac_tx_ready", 64'(mac_tx_ready), 64'(e_mr));
    chk("side_tready", 64'(side_tready), 64'(e_sr));
    starve = m_wait >= MW;
    if (r) begin
      m_st = 0; m_wait = 0; m_burst = 0; n_side = '0; n_hold = '0;
    end else begin
      if (e_sr) n_side++;
      if (m_st == 2) n_hold++;
      m_wait = (!sv || e_sr) ? 0 : (m_wait < 65535 ? m_wait + 1 : m_wait);
      if (m_st == 0) begin
        if (start) m_st = 1;
      end else if (m_st == 1) begin
        if (term) begin m_st = starve ? 2 : 0; m_burst = 0; end
      end else begin
        if (e_sr) m_burst++;
        if (!sv || m_burst == MB) m_st = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("xgmii_txd", xgmii_txd, e_d);
    chk("xgmii_txc", 64'(xgmii_txc), 64'(e_c));
    chk("sched_state", 64'(sched_state), 64'(m_st));
`ifdef SCHED_STATS_EN
    chk("stat_side_words", 64'(stat_side_words), 64'(n_side));
    chk("stat_hold_cycles", 64'(stat_hold_cycles), 64'(n_hold));
`endif
  endtask
  task automatic run(input logic sv, input logic [55:0] sd, input logic r);
    logic [71:0] w;
    logic acc;
    w = (mq.size() != 0) ? mq[0] : {IDLE, 8'hff};
    acc = !r && m_st != 2;
    step(w[71:8], w[7:0], sv, sd, r);
    if (acc && mq.size() != 0) void'(mq.pop_front());
  endtask
  task automatic add_frame(input int n, input int lane, input logic l4);
    logic [63:0] d;
    logic [7:0] c;
    mq.push_back(l4 ? {64'hd55555fb07070707, 8'h1f} : {64'hd5555555555555fb, 8'h01});
    for (int i = 0; i < n; i++) mq.push_back({$urandom(), $urandom(), 8'h00});
    d = {$urandom(), $urandom()};
    c = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == lane) begin c[i] = 1'b1; d[8*i +: 8] = 8'hfd; end
      if (i > lane) begin c[i] = 1'b1; d[8*i +: 8] = 8'h07; end
    end
    mq.push_back({d, c});
  endtask
  initial begin
    logic [63:0] held;
    int hc;
    @(posedge clk);
    #1;
    run(1'b0, '0, 1'b1);
    run(1'b1, 56'h0123456789abcd, 1'b1);
    chk("reset_txd", xgmii_txd, IDLE);
    for (int i = 0; i < 5; i++) begin
      run(1'b1, 56'h0123456789abcd, 1'b0);
      chk("idle_side_word", xgmii_txd, 64'h0123456789abcd5c);
    end
    add_frame(8, 3, 1'b0);
    mq.push_back({IDLE, 8'hff});
    for (int i = 0; i < 10; i++) run(i >= 5, 56'haabbccddeeff11, 1'b0);
    run(1'b1, 56'haabbccddeeff11, 1'b0);
    chk("side_after_term", xgmii_txd, 64'haabbccddeeff115c);
    add_frame(100, 5, 1'b0);
    add_frame(2, 0, 1'b0);
    held = 64'hd5555555555555fb;
    for (int i = 0; i < 200 && sched_state != 2'd2; i++) run(1'b1, 56'(i), 1'b0);
    chk("hold_entered", 64'(sched_state), 64'd2);
    hc = 0;
    for (int i = 0; i < 20 && sched_state == 2'd2; i++) begin run(1'b1, 56'(100 + i), 1'b0); hc++; end
    chk("hold_burst_len", 64'(hc), 64'(MB));
    run(1'b0, '0, 1'b0);
    chk("held_word_out", xgmii_txd, held);
    for (int i = 0; i < 5; i++) run(1'b0, '0, 1'b0);
    add_frame(20, 7, 1'b1);
    for (int i = 0; i < 200 && sched_state != 2'd2; i++) run(1'b1, 56'(i), 1'b0);
    run(1'b1, 56'h1, 1'b0);
    run(1'b1, 56'h2, 1'b0);
    run(1'b0, '0, 1'b0);
    chk("drop_exit_idle", xgmii_txd, IDLE);
    chk("drop_exit_state", 64'(sched_state), 64'd0);
    mq.push_back({OS_D, 8'hf1});
    run(1'b1, 56'h77, 1'b0);
    chk("ordered_set", xgmii_txd, OS_D);
    add_frame(12, 2, 1'b0);
    for (int i = 0; i < 200 && sched_state != 2'd2; i++) run(1'b1, 56'(i), 1'b0);
    run(1'b1, 56'h5, 1'b0);
    run(1'b1, 56'h6, 1'b0);
    run(1'b1, 56'h7, 1'b1);
    chk("rst_hold_state", 64'(sched_state), 64'd0);
    chk("rst_hold_txd", xgmii_txd, IDLE);
    mq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (mq.size() == 0) begin
        case ($urandom_range(0, 5))
          0, 1, 2: add_frame($urandom_range(0, 20), $urandom_range(0, 7), $urandom_range(0, 3) == 0);
          3: mq.push_back({OS_D, 8'hf1});
          4: mq.push_back({64'hfefefefefefefefe, 8'hff});
          default: for (int i = 0; i < $urandom_range(1, 4); i++) mq.push_back({IDLE, 8'hff});
        endcase
      end
      run($urandom_range(0, 3) != 0, 56'({$urandom(), $urandom()}), $urandom_range(0, 499) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/xgmii_ipg_tx_sched.md
Name: xgmii_ipg_tx_sched

Overview:
- Time-shares the 64-bit XGMII TX path between the MAC stream and a side-channel message queue.
- Sits directly upstream of the 10GBASE-R TX encoder.
- Side words ride in the inter-packet gap by replacing MAC all-IDLE words.
- A side word starved for MAX_WAIT cycles forces a hold of the MAC after its current frame ends, so the side queue can drain a bounded burst.

Parameters:
- SIDE_CHAR, 8'h5c: lane-0 control character marking a side word.
- MAX_WAIT, 64: cycles a side word may wait before the block forces a hold; range 1..65535.
- MAX_BURST, 4: maximum side words sent per forced hold; range 1..255.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- mac_txd  in  64  MAC XGMII data.
- mac_txc  in  8  MAC XGMII control.
- mac_tx_ready  out  1  MAC word accepted this cycle; when low, the MAC holds txd/txc stable.
- side_tdata  in  56  side payload.
- side_tvalid  in  1  side payload valid.
- side_tready  out  1  side payload accepted this cycle.
- xgmii_txd  out  64  to encoder, registered.
- xgmii_txc  out  8  to encoder, registered.
- sched_state  out  2  current state: 0=GAP, 1=FRAME, 2=HOLD.

Behaviour:
- Clocking and reset: single clock; reset synchronous, active-high. Port names are clk/rst.
- Reset values:
  - xgmii_txd = 64'h0707070707070707, xgmii_txc = 8'hff.
  - mac_tx_ready = 0 during reset, 1 on the first cycle after.
  - side_tready = 0; state = GAP; wait_cnt = 0; burst_cnt = 0.
- Latency: exactly 1 cycle from an accepted word to xgmii_txd/txc.
- Side word encoding: txc = 8'hff, txd = {side_tdata, SIDE_CHAR}.
- Word classification (on mac_txd/mac_txc):
  - IDLE: txc == ff and all eight bytes == 07.
  - START: (txc[0] and byte0 == fb) or (txc == 1f and byte4 == fb).
  - TERM: any lane i with txc[i] and byte i == fd.
- Starvation counter wait_cnt (16 bit):
  - Increments each cycle side_tvalid && !side_tready; saturates.
  - Clears on a side handshake or when side_tvalid is low.
  - starve = (wait_cnt >= MAX_WAIT).
- GAP state: mac_tx_ready = 1.
  - Current MAC word IDLE and side_tvalid: side_tready = 1; output the side word; the MAC idle is consumed and dropped.
  - Otherwise pass the MAC word through.
  - START accepted: go to FRAME.
  - START and TERM in the same word (lane-4 start cannot terminate in that word): treated as START only.
- FRAME state: mac_tx_ready = 1, side_tready = 0, MAC words pass through unmodified. Insertion inside a frame is forbidden.
  - TERM accepted and starve: go to HOLD, burst_cnt = 0.
  - TERM accepted and not starve: go to GAP.
- HOLD state: mac_tx_ready = 0, MAC inputs are ignored.
  - side_tvalid: side_tready = 1, emit the side word, increment burst_cnt.
  - No side_tvalid: emit an all-IDLE word.
  - Leave to GAP when burst_cnt reaches MAX_BURST on a handshake, or on the first cycle side_tvalid is low.
- side_tready depends combinationally on side_tvalid, mac_txc, mac_txd and state. The side source must not make side_tvalid depend on side_tready.
- Non-IDLE control words in GAP (LPI, ordered sets, error) pass through and are never replaced.
- Reset mid-frame or mid-hold: state returns to GAP. The output word in the reset cycle is IDLE. An in-flight side handshake in that cycle does not occur.

Optional Feature:
- Macro: SCHED_STATS_EN.
- Defined: adds two outputs.
  - stat_side_words (32 bit): counts every side handshake.
  - stat_hold_cycles (32 bit): counts cycles in HOLD.
  - Both wrap on overflow and clear on rst.
- Undefined: these ports and their counters are absent. All other behaviour is identical.

Test Plan:
- Continuous IDLE from MAC with side_tvalid=1 and data 56'h0123456789abcd:
  - Every cycle emits txc=ff, txd=64'h0123456789abcd5c one cycle later.
  - side_tready=1 and mac_tx_ready=1 throughout.
- MAC frame (START word, 8 data words, TERM in lane 3) with side_tvalid raised mid-frame and MAX_WAIT=64:
  - All 10 MAC words reach the output bit-exact; side_tready=0 during FRAME.
  - The side word goes out on the first IDLE after TERM.
- Long frame (100 data words) with side_tvalid held high from word 1, MAX_WAIT=8, MAX_BURST=4:
  - Cycle after TERM: state=HOLD, mac_tx_ready=0.
  - Exactly 4 side words emitted, then state=GAP.
  - The MAC word held across HOLD is output unchanged.
- HOLD entered, then side_tvalid drops after 2 words:
  - 2 side words emitted; exit to GAP on the first cycle side_tvalid is low, with an IDLE word out that cycle.
- MAC sends ordered set (txc=f1, byte0=9c) with side_tvalid=1:
  - Ordered set passes unchanged; side_tready=0 that cycle.
- rst pulsed during HOLD (burst_cnt=2):
  - Next cycle: state=GAP, xgmii_txd=0707070707070707, xgmii_txc=ff.
  - With SCHED_STATS_EN, both counters read 0.
